// File: rtl/muldiv_sequencer.sv
// Iterative radix-2 shift-add multiplier for the EX stage; owns the HI/LO pair.
// A MULT/MULTU is accepted in IDLE or DONE, iterates WIDTH cycles in CALC, applies
// the sign in FIX, then writes HI/LO and pulses done for one cycle in DONE.
// Ports:
//   clk_i, rst_n      clock and async active-low reset
//   mul_req_i         EX holds MULT/MULTU;  mul_signed_i: 1 = MULT, 0 = MULTU
//   op_a_i, op_b_i    rs / rt operands
//   hilo_rd_i         EX holds MFHI/MFLO
//   flush_i           squash the in-flight multiply
//   stall_o           freeze IF/ID/EX while HI/LO is being computed
//   busy_o, done_o    CALC|FIX indicator, one-cycle completion pulse
//   hi_o, lo_o        HI/LO registers
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             mul_req_i,
  input  logic             mul_signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             hilo_rd_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    count_q;
  logic [WIDTH-1:0]   mcand_q;
  // {carry guard, upper accumulator, multiplier shifting out the bottom}
  logic [2*WIDTH:0]   prod_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   prod_step;
  logic [2*WIDTH-1:0] res, res_fix;

  // Magnitudes for MULT; |-2^(W-1)| wraps to 2^(W-1), which is correct unsigned.
  always_comb begin
    a_mag = op_a_i;
    b_mag = op_b_i;
    if (mul_signed_i && op_a_i[WIDTH-1]) a_mag = ~op_a_i + WIDTH'(1);
    if (mul_signed_i && op_b_i[WIDTH-1]) b_mag = ~op_b_i + WIDTH'(1);
  end

  // One shift-add iteration: conditionally add into the upper half, shift right.
  always_comb begin
    sum       = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {1'b0, sum, prod_q[WIDTH-1:1]};
    res       = prod_q[2*WIDTH-1:0];
    res_fix   = neg_q ? (~res + (2*WIDTH)'(1)) : res;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (flush_i) begin
      // Flush beats both a new accept and the FIX write.
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (mul_req_i) begin
            mcand_q <= a_mag;
            prod_q  <= {1'b0, {WIDTH{1'b0}}, b_mag};
            neg_q   <= mul_signed_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
            count_q <= '0;
            state_q <= StCalc;
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          prod_q  <= prod_step;
          count_q <= count_q + CntW'(1);
          if (count_q == CntW'(WIDTH - 1)) state_q <= StFix;
        end
        StFix: begin
          {hi_q, lo_q} <= res_fix;
          state_q      <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state_q == StCalc) || (state_q == StFix);
    done_o  = (state_q == StDone);
    stall_o = busy_o && (mul_req_i || hilo_rd_i);
    hi_o    = hi_q;
    lo_o    = lo_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b0;
  logic          mul_req = 1'b0, mul_signed = 1'b0, hilo_rd = 1'b0, flush = 1'b0;
  logic [W-1:0]  op_a = '0, op_b = '0;
  logic          stall_o, busy_o, done_o;
  logic [W-1:0]  hi_o, lo_o;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .mul_req_i    (mul_req),
    .mul_signed_i (mul_signed),
    .op_a_i       (op_a),
    .op_b_i       (op_b),
    .hilo_rd_i    (hilo_rd),
    .flush_i      (flush),
    .stall_o      (stall_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2*W-1:0] prod;
    int             done_cyc;
  } exp_t;

  exp_t           exp_q[$];
  int             cyc = 0;
  int             n_cmp = 0;
  int             n_err = 0;
  int             busy_from = 1;
  int             busy_to = 0;
  logic [2*W-1:0] model_hilo = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input bit sgn, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb;
    logic [2*W-1:0] ua, ub;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One pipeline cycle: drive inputs, update the timing model, check stall/busy.
  task automatic step(input bit req, input bit sgn, input logic [W-1:0] a,
                      input logic [W-1:0] b, input bit rd, input bit fl);
    int  c;
    bit  busy_now;
    exp_t e;
    @(posedge clk_i);
    #1;
    c        = cyc;
    busy_now = (c >= busy_from) && (c <= busy_to);
    mul_req = req; mul_signed = sgn; op_a = a; op_b = b; hilo_rd = rd; flush = fl;
    if (fl) begin
      if (busy_now) begin
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        busy_to = c;
      end
    end else if (req && !busy_now) begin
      e.prod     = ref_mul(sgn, a, b);
      e.done_cyc = c + W + 2;
      exp_q.push_back(e);
      busy_from = c + 1;
      busy_to   = c + W + 1;
    end
    @(negedge clk_i);
    check("busy", 64'(busy_o), 64'(busy_now));
    check("stall", 64'(stall_o), 64'(busy_now && (req || rd)));
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, '0, 0, 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_n) begin
        if (done_o) begin
          if (exp_q.size() == 0) begin
            check("done_unexpected", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("done_cycle", 64'(cyc), 64'(e.done_cyc));
            model_hilo = e.prod;
          end
        end else if (exp_q.size() > 0 && exp_q[0].done_cyc == cyc) begin
          check("done_missing", 64'(0), 64'(1));
          model_hilo = exp_q[0].prod;
          void'(exp_q.pop_front());
        end
        check("hilo", {hi_o, lo_o}, model_hilo);
      end
    end
  end

  initial begin
    int c0;
    #2;
    check("rst_hilo", {hi_o, lo_o}, 64'(0));
    check("rst_flags", 64'({stall_o, busy_o, done_o}), 64'(0));
    #10 rst_n = 1'b1;

    // Small unsigned, signed negative, and full-range corner products.
    step(1, 0, 32'd7, 32'd6, 0, 0);
    idle(40);
    check("multu_7x6", {hi_o, lo_o}, 64'h0000_0000_0000_002A);
    step(1, 1, 32'hFFFF_FFFD, 32'd5, 0, 0);
    idle(40);
    check("mult_m3x5", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
    step(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    idle(36);
    check("multu_max", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
    step(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    idle(36);
    check("mult_m1xm1", {hi_o, lo_o}, 64'h0000_0000_0000_0001);
    step(1, 1, 32'h8000_0000, 32'h8000_0000, 0, 0);
    idle(36);

    // MFHI during CALC stalls; a MULT held in EX is accepted in DONE.
    step(1, 0, 32'h1234_5678, 32'h0000_1000, 0, 0);
    idle(4);
    repeat (W + 3) step(1, 1, 32'hDEAD_BEEF, 32'hFFFF_FF00, 1, 0);
    idle(40);

    // Flush in CALC and in FIX: no done pulse, HI/LO untouched.
    step(1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
    idle(40);
    step(1, 1, pick(), pick(), 0, 0);
    idle(9);
    step(0, 0, '0, '0, 0, 1);
    idle(5);
    step(1, 0, 32'hFFFF_FFFF, 32'h3, 0, 0);
    idle(W);
    step(1, 0, 32'h5, 32'h5, 0, 1);
    idle(5);

    // Asynchronous reset mid-operation.
    step(1, 0, 32'hAAAA_AAAA, 32'h5555_5555, 0, 0);
    c0 = cyc;
    idle(19);
    @(posedge clk_i);
    #1;
    mul_req = 0; hilo_rd = 0; flush = 0;
    #2;
    rst_n      = 1'b0;
    exp_q.delete();
    model_hilo = '0;
    busy_from  = 1;
    busy_to    = 0;
    #1;
    check("rst_mid_hilo", {hi_o, lo_o}, 64'(0));
    check("rst_mid_flags", 64'({busy_o, done_o, stall_o}), 64'(0));
    @(negedge clk_i);
    #1 rst_n = 1'b1;
    step(1, 0, 32'd2, 32'd3, 0, 0);
    idle(40);
    check("multu_2x3", {hi_o, lo_o}, 64'd6);

    // Randomized traffic.
    repeat (4000) begin
      if ($urandom % 8 == 0) idle(1 + int'($urandom % 5));
      step($urandom % 3 != 0, 1'($urandom), pick(), pick(), 1'($urandom),
           ($urandom % 64) == 0);
    end
    idle(40);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
